// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit width and the 2-bit flit-type field carried
// in the top bits of every flit.
package noc_pkg;

    localparam int FLIT_W = 20;
    localparam int FT_HI  = FLIT_W - 1;
    localparam int FT_LO  = FLIT_W - 2;

    localparam logic [1:0] FT_BODY   = 2'b00;
    localparam logic [1:0] FT_HEAD   = 2'b01;
    localparam logic [1:0] FT_TAIL   = 2'b10;
    localparam logic [1:0] FT_SINGLE = 2'b11;

    function automatic logic [1:0] flit_type(input logic [FLIT_W-1:0] flit);
        return flit[FT_HI:FT_LO];
    endfunction

    // True for flits that may open a packet (HEAD or SINGLE).
    function automatic logic is_opening(input logic [1:0] ft);
        return (ft == FT_HEAD) || (ft == FT_SINGLE);
    endfunction

endpackage

// File: rtl/noc_credit_fifo.sv
// Per-leaf synchronous FIFO; the head flit is visible combinationally so the
// arbiter can inspect its type before deciding to pop.
module noc_credit_fifo
    import noc_pkg::*;
#(
    parameter int WIDTH = FLIT_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is dropped even if a pop happens on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: the storage array has no reset; the pointers and count alone decide
    // which entries are valid, so clearing the data would only cost flops.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/hub_uplink_arbiter.sv
// Cluster-hub uplink: per-leaf FIFOs, packet-granular round-robin onto one
// credit-flow-controlled channel. Define HUB_UPLINK_PERF_EN for perf counters.
module hub_uplink_arbiter
    import noc_pkg::*;
#(
    parameter int NUM_IN      = 4,
    parameter int IN_DEPTH    = 4,
    parameter int OUT_CREDITS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_IN*FLIT_W-1:0]   in_data,
    input  logic [NUM_IN-1:0]          in_valid,
    output logic [NUM_IN-1:0]          in_co,
    output logic [FLIT_W-1:0]          out_data,
    output logic                       out_valid,
    input  logic                       out_ci,
    output logic [$clog2(NUM_IN)-1:0]  grant_id,
    output logic                       busy,
`ifdef HUB_UPLINK_PERF_EN
    output logic [NUM_IN*16-1:0]       perf_flits,
    output logic [15:0]                perf_stall,
`endif
    output logic                       err
);

    localparam int ID_W   = $clog2(NUM_IN);
    localparam int CRED_W = $clog2(OUT_CREDITS + 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [FLIT_W-1:0] fifo_head [NUM_IN];
    logic [NUM_IN-1:0] fifo_full;
    logic [NUM_IN-1:0] fifo_empty;
    logic [NUM_IN-1:0] pop;

    logic [0:0]        state;
    logic [0:0]        state_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic [CRED_W-1:0] credit;
    logic              credit_avail;

    logic [NUM_IN-1:0] cand;
    logic [NUM_IN-1:0] orphan;
    logic              found;
    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   cidx;
    logic              fwd;
    logic [ID_W-1:0]   src;
    logic              err_set;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_in
        noc_credit_fifo #(
            .WIDTH (FLIT_W),
            .DEPTH (IN_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (in_valid[i]),
            .wdata (in_data[i*FLIT_W +: FLIT_W]),
            .pop   (pop[i]),
            .head  (fifo_head[i]),
            .full  (fifo_full[i]),
            .empty (fifo_empty[i])
        );
    end

    assign credit_avail = (credit != '0);
    assign busy         = (state == ST_LOCKED);

    // Classify every non-empty head: openers compete, stray BODY/TAIL flits are orphans.
    always_comb begin
        cand   = '0;
        orphan = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (!fifo_empty[i]) begin
                if (is_opening(flit_type(fifo_head[i]))) begin
                    cand[i] = 1'b1;
                end else begin
                    orphan[i] = 1'b1;
                end
            end
        end
    end

    // Round-robin search beginning one past the last winner.
    always_comb begin
        found  = 1'b0;
        winner = rr_ptr;
        cidx   = '0;
        for (int k = 1; k <= NUM_IN; k++) begin
            cidx = ID_W'((int'(rr_ptr) + k) % NUM_IN);
            if (!found && cand[cidx]) begin
                found  = 1'b1;
                winner = cidx;
            end
        end
    end

    // NOTE: every signal gets a default before the branches so this block
    // stays purely combinational and cannot infer a latch.
    always_comb begin
        pop       = '0;
        fwd       = 1'b0;
        src       = grant_id;
        state_nxt = state;
        if (state == ST_IDLE) begin
            pop = orphan;
            if (found && credit_avail) begin
                pop[winner] = 1'b1;
                fwd         = 1'b1;
                src         = winner;
                if (flit_type(fifo_head[winner]) == FT_HEAD) begin
                    state_nxt = ST_LOCKED;
                end
            end
        end else if (!fifo_empty[grant_id] && credit_avail) begin
            pop[grant_id] = 1'b1;
            fwd           = 1'b1;
            if (flit_type(fifo_head[grant_id]) == FT_TAIL) begin
                state_nxt = ST_IDLE;
            end
        end
    end

    assign err_set = (|(in_valid & fifo_full))
                   || ((state == ST_IDLE) && (|orphan))
                   || (out_ci && (credit == CRED_W'(OUT_CREDITS)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            grant_id  <= '0;
            rr_ptr    <= '0;
            credit    <= CRED_W'(OUT_CREDITS);
            out_valid <= 1'b0;
            out_data  <= '0;
            in_co     <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_valid <= fwd;
            in_co     <= pop;
            if (fwd) begin
                out_data <= fifo_head[src];
                grant_id <= src;
                rr_ptr   <= src;
            end
            // A pop and a returned credit on the same edge cancel out.
            if (fwd && !out_ci) begin
                credit <= credit - 1'b1;
            end else if (!fwd && out_ci && (credit != CRED_W'(OUT_CREDITS))) begin
                credit <= credit + 1'b1;
            end
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

`ifdef HUB_UPLINK_PERF_EN
    logic stall;

    assign stall = !credit_avail
                && ((state == ST_IDLE) ? (|cand) : !fifo_empty[grant_id]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_flits <= '0;
            perf_stall <= '0;
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (fwd && (src == ID_W'(i)) && (perf_flits[i*16 +: 16] != 16'hFFFF)) begin
                    perf_flits[i*16 +: 16] <= perf_flits[i*16 +: 16] + 16'd1;
                end
            end
            if (stall && (perf_stall != 16'hFFFF)) begin
                perf_stall <= perf_stall + 16'd1;
            end
        end
    end
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_hub_uplink_arbiter.sv
// Self-checking bench: directed vector table, an asynchronous mid-packet reset
// sequence, and randomized traffic against a queue-based reference model.
module tb_hub_uplink_arbiter;
    import noc_pkg::*;

    localparam int NUM_IN      = 4;
    localparam int IN_DEPTH    = 4;
    localparam int OUT_CREDITS = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_IN*FLIT_W-1:0] in_data;
    logic [NUM_IN-1:0]        in_valid;
    logic [NUM_IN-1:0]        in_co;
    logic [FLIT_W-1:0]        out_data;
    logic                     out_valid;
    logic                     out_ci;
    logic [1:0]               grant_id;
    logic                     busy;
    logic                     err;
`ifdef HUB_UPLINK_PERF_EN
    logic [NUM_IN*16-1:0]     perf_flits;
    logic [15:0]              perf_stall;
`endif

    hub_uplink_arbiter #(
        .NUM_IN      (NUM_IN),
        .IN_DEPTH    (IN_DEPTH),
        .OUT_CREDITS (OUT_CREDITS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_co      (in_co),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ci     (out_ci),
        .grant_id   (grant_id),
        .busy       (busy),
`ifdef HUB_UPLINK_PERF_EN
        .perf_flits (perf_flits),
        .perf_stall (perf_stall),
`endif
        .err        (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [FLIT_W-1:0] mq [NUM_IN][$];
    int                m_credit;
    int                m_ptr;
    int                m_lock;
    int                m_grant;
    bit                m_err;
    bit                m_ov;
    logic [FLIT_W-1:0] m_od;
    logic [NUM_IN-1:0] m_co;

    function automatic logic [1:0] ty(input logic [FLIT_W-1:0] f);
        return f[FLIT_W-1 -: 2];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_IN; i++) mq[i].delete();
        m_credit = OUT_CREDITS;
        m_ptr    = 0;
        m_lock   = -1;
        m_grant  = 0;
        m_err    = 0;
        m_ov     = 0;
        m_od     = '0;
        m_co     = '0;
    endtask

    // One clock edge of the arbiter, computed from the rules on queues.
    task automatic model_step(input logic [NUM_IN-1:0] vld, input logic [NUM_IN*FLIT_W-1:0] d,
                              input logic ci);
        bit full [NUM_IN];
        int win;
        bit fwd;
        logic [FLIT_W-1:0] f;
        for (int i = 0; i < NUM_IN; i++) full[i] = (mq[i].size() == IN_DEPTH);
        m_ov = 0;
        m_co = '0;
        fwd  = 0;
        if (m_lock < 0) begin
            win = -1;
            for (int k = 1; k <= NUM_IN; k++) begin
                int i;
                i = (m_ptr + k) % NUM_IN;
                if (win < 0 && mq[i].size() > 0 && (ty(mq[i][0]) == FT_HEAD || ty(mq[i][0]) == FT_SINGLE))
                    win = i;
            end
            for (int i = 0; i < NUM_IN; i++) begin
                if (mq[i].size() > 0 && (ty(mq[i][0]) == FT_BODY || ty(mq[i][0]) == FT_TAIL)) begin
                    f = mq[i].pop_front();
                    m_co[i] = 1'b1;
                    m_err   = 1;
                end
            end
            if (win >= 0 && m_credit > 0) begin
                f       = mq[win].pop_front();
                fwd     = 1;
                m_od    = f;
                m_co[win] = 1'b1;
                m_grant = win;
                m_ptr   = win;
                if (ty(f) == FT_HEAD) m_lock = win;
            end
        end else if (mq[m_lock].size() > 0 && m_credit > 0) begin
            f    = mq[m_lock].pop_front();
            fwd  = 1;
            m_od = f;
            m_co[m_lock] = 1'b1;
            if (ty(f) == FT_TAIL) m_lock = -1;
        end
        m_ov = fwd;
        if (ci && m_credit == OUT_CREDITS) m_err = 1;
        if (fwd && !ci) m_credit--;
        else if (!fwd && ci && m_credit < OUT_CREDITS) m_credit++;
        for (int i = 0; i < NUM_IN; i++) begin
            if (vld[i]) begin
                if (full[i]) m_err = 1;
                else mq[i].push_back(d[i*FLIT_W +: FLIT_W]);
            end
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, " out_valid"}, 32'(out_valid), 32'(m_ov));
        if (m_ov) check({tag, " out_data"}, 32'(out_data), 32'(m_od));
        check({tag, " in_co"}, 32'(in_co), 32'(m_co));
        check({tag, " grant_id"}, 32'(grant_id), m_grant);
        check({tag, " busy"}, 32'(busy), 32'(m_lock >= 0));
        check({tag, " err"}, 32'(err), 32'(m_err));
    endtask

    // ---------------- drive helpers ----------------
    function automatic logic [NUM_IN*FLIT_W-1:0] ld(input int leaf, input logic [FLIT_W-1:0] f);
        return {60'd0, f} << (leaf * FLIT_W);
    endfunction

    task automatic cycle(input logic [NUM_IN-1:0] vld, input logic [NUM_IN*FLIT_W-1:0] d,
                         input logic ci);
        in_valid = vld;
        in_data  = d;
        out_ci   = ci;
        model_step(vld, d, ci);
        @(posedge clk);
        @(negedge clk);
        in_valid = '0;
        out_ci   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b0;
        in_valid = '0;
        in_data  = '0;
        out_ci   = 1'b0;
        model_reset();
        @(negedge clk);
        check("reset out_valid", 32'(out_valid), 0);
        check("reset out_data", 32'(out_data), 0);
        check("reset in_co", 32'(in_co), 0);
        check("reset grant_id", 32'(grant_id), 0);
        check("reset busy", 32'(busy), 0);
        check("reset err", 32'(err), 0);
        rst = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit                       rst_first;
        logic [NUM_IN-1:0]        vld;
        logic [NUM_IN*FLIT_W-1:0] data;
        logic                     ci;
        logic                     ov;
        logic [FLIT_W-1:0]        od;
        logic [NUM_IN-1:0]        co;
        logic [1:0]               gid;
        logic                     bsy;
        logic                     er;
    } vec_t;

    vec_t vt[$];

    task automatic v(input bit r, input logic [3:0] vld, input logic [79:0] d, input logic ci,
                     input logic ov, input logic [19:0] od, input logic [3:0] co,
                     input logic [1:0] gid, input logic bsy, input logic er);
        vec_t e;
        e = '{r, vld, d, ci, ov, od, co, gid, bsy, er};
        vt.push_back(e);
    endtask

    int rem [NUM_IN];

    function automatic logic [FLIT_W-1:0] gen_flit(input int leaf, input bit inject);
        logic [1:0] t;
        if (rem[leaf] < 0) begin
            if ($urandom_range(2) == 0) t = FT_SINGLE;
            else begin
                t = FT_HEAD;
                rem[leaf] = $urandom_range(3);
            end
        end else if (rem[leaf] == 0) begin
            t = FT_TAIL;
            rem[leaf] = -1;
        end else begin
            t = FT_BODY;
            rem[leaf]--;
        end
        if (inject && $urandom_range(49) == 0) t = 2'($urandom_range(3));
        return {t, 18'($urandom)};
    endfunction

    task automatic random_phase(input string tag, input int n, input bit inject);
        logic [NUM_IN-1:0]        vld;
        logic [NUM_IN*FLIT_W-1:0] d;
        logic                     ci;
        for (int i = 0; i < NUM_IN; i++) rem[i] = -1;
        for (int c = 0; c < n; c++) begin
            vld = '0;
            d   = '0;
            for (int i = 0; i < NUM_IN; i++) begin
                if ($urandom_range(99) < 40 &&
                    (mq[i].size() < IN_DEPTH || (inject && $urandom_range(15) == 0))) begin
                    vld[i] = 1'b1;
                    d      = d | ld(i, gen_flit(i, inject));
                end
            end
            if (m_credit < OUT_CREDITS) ci = 1'($urandom_range(1));
            else ci = inject && ($urandom_range(199) == 0);
            cycle(vld, d, ci);
            compare_model($sformatf("%s%0d", tag, c));
        end
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = '0;
        in_data  = '0;
        out_ci   = 1'b0;
        model_reset();

        // Two simultaneous 3-flit packets: leaf 1 first, then leaf 0.
        v(1, 4'b0011, ld(0, 20'h40A00) | ld(1, 20'h41A00), 0, 0, 20'h0,     4'b0000, 0, 0, 0);
        v(0, 4'b0011, ld(0, 20'h00A01) | ld(1, 20'h01A01), 0, 1, 20'h41A00, 4'b0010, 1, 1, 0);
        v(0, 4'b0011, ld(0, 20'h80A02) | ld(1, 20'h81A02), 1, 1, 20'h01A01, 4'b0010, 1, 1, 0);
        v(0, 4'b0000, 80'h0, 1, 1, 20'h81A02, 4'b0010, 1, 0, 0);
        v(0, 4'b0000, 80'h0, 1, 1, 20'h40A00, 4'b0001, 0, 1, 0);
        v(0, 4'b0000, 80'h0, 1, 1, 20'h00A01, 4'b0001, 0, 1, 0);
        v(0, 4'b0000, 80'h0, 1, 1, 20'h80A02, 4'b0001, 0, 0, 0);
        v(0, 4'b0000, 80'h0, 1, 0, 20'h0,     4'b0000, 0, 0, 0);
        // SINGLE on leaf 2.
        v(0, 4'b0100, ld(2, 20'hC0123), 0, 0, 20'h0,     4'b0000, 0, 0, 0);
        v(0, 4'b0000, 80'h0,            0, 1, 20'hC0123, 4'b0100, 2, 0, 0);
        v(0, 4'b0000, 80'h0,            1, 0, 20'h0,     4'b0000, 2, 0, 0);
        // 6-flit packet on leaf 1 with credits withheld.
        v(0, 4'b0010, ld(1, 20'h43000), 0, 0, 20'h0,     4'b0000, 2, 0, 0);
        v(0, 4'b0010, ld(1, 20'h03001), 0, 1, 20'h43000, 4'b0010, 1, 1, 0);
        v(0, 4'b0010, ld(1, 20'h03002), 0, 1, 20'h03001, 4'b0010, 1, 1, 0);
        v(0, 4'b0010, ld(1, 20'h03003), 0, 1, 20'h03002, 4'b0010, 1, 1, 0);
        v(0, 4'b0010, ld(1, 20'h03004), 0, 1, 20'h03003, 4'b0010, 1, 1, 0);
        v(0, 4'b0010, ld(1, 20'h83005), 0, 0, 20'h0,     4'b0000, 1, 1, 0);
        v(0, 4'b0000, 80'h0,            0, 0, 20'h0,     4'b0000, 1, 1, 0);
        v(0, 4'b0000, 80'h0,            1, 0, 20'h0,     4'b0000, 1, 1, 0);
        v(0, 4'b0000, 80'h0,            0, 1, 20'h03004, 4'b0010, 1, 1, 0);
        v(0, 4'b0000, 80'h0,            0, 0, 20'h0,     4'b0000, 1, 1, 0);
        v(0, 4'b0000, 80'h0,            1, 0, 20'h0,     4'b0000, 1, 1, 0);
        v(0, 4'b0000, 80'h0,            0, 1, 20'h83005, 4'b0010, 1, 0, 0);
        for (int i = 0; i < 4; i++) v(0, 4'b0000, 80'h0, 1, 0, 20'h0, 4'b0000, 1, 0, 0);
        // Drain all credits with SINGLEs, then overflow leaf 3.
        v(0, 4'b0001, ld(0, 20'hC0000), 0, 0, 20'h0,     4'b0000, 1, 0, 0);
        v(0, 4'b0001, ld(0, 20'hC0001), 0, 1, 20'hC0000, 4'b0001, 0, 0, 0);
        v(0, 4'b0001, ld(0, 20'hC0002), 0, 1, 20'hC0001, 4'b0001, 0, 0, 0);
        v(0, 4'b0001, ld(0, 20'hC0003), 0, 1, 20'hC0002, 4'b0001, 0, 0, 0);
        v(0, 4'b0000, 80'h0,            0, 1, 20'hC0003, 4'b0001, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            v(0, 4'b1000, ld(3, 20'h47000 + 20'(i)), 0, 0, 20'h0, 4'b0000, 0, 0, 0);
        v(0, 4'b1000, ld(3, 20'h47004), 0, 0, 20'h0, 4'b0000, 0, 0, 1);
        // Reset restores err=0 and exactly OUT_CREDITS credits.
        v(1, 4'b0001, ld(0, 20'hC1000), 0, 0, 20'h0,     4'b0000, 0, 0, 0);
        v(0, 4'b0001, ld(0, 20'hC1001), 0, 1, 20'hC1000, 4'b0001, 0, 0, 0);
        v(0, 4'b0001, ld(0, 20'hC1002), 0, 1, 20'hC1001, 4'b0001, 0, 0, 0);
        v(0, 4'b0001, ld(0, 20'hC1003), 0, 1, 20'hC1002, 4'b0001, 0, 0, 0);
        v(0, 4'b0001, ld(0, 20'hC1004), 0, 1, 20'hC1003, 4'b0001, 0, 0, 0);
        v(0, 4'b0000, 80'h0,            0, 0, 20'h0,     4'b0000, 0, 0, 0);
        v(0, 4'b0000, 80'h0,            1, 0, 20'h0,     4'b0000, 0, 0, 0);
        v(0, 4'b0000, 80'h0,            0, 1, 20'hC1004, 4'b0001, 0, 0, 0);
        for (int i = 0; i < 4; i++) v(0, 4'b0000, 80'h0, 1, 0, 20'h0, 4'b0000, 0, 0, 0);
        // Orphan BODY at leaf 0, then a SINGLE behind it.
        v(0, 4'b0001, ld(0, 20'h05555), 0, 0, 20'h0,     4'b0000, 0, 0, 0);
        v(0, 4'b0001, ld(0, 20'hC5556), 0, 0, 20'h0,     4'b0001, 0, 0, 1);
        v(0, 4'b0000, 80'h0,            0, 1, 20'hC5556, 4'b0001, 0, 0, 1);
        v(0, 4'b0000, 80'h0,            1, 0, 20'h0,     4'b0000, 0, 0, 1);

        foreach (vt[n]) begin
            if (vt[n].rst_first) do_reset();
            cycle(vt[n].vld, vt[n].data, vt[n].ci);
            check($sformatf("vec%0d out_valid", n), 32'(out_valid), 32'(vt[n].ov));
            if (vt[n].ov) check($sformatf("vec%0d out_data", n), 32'(out_data), 32'(vt[n].od));
            check($sformatf("vec%0d in_co", n), 32'(in_co), 32'(vt[n].co));
            check($sformatf("vec%0d grant_id", n), 32'(grant_id), 32'(vt[n].gid));
            check($sformatf("vec%0d busy", n), 32'(busy), 32'(vt[n].bsy));
            check($sformatf("vec%0d err", n), 32'(err), 32'(vt[n].er));
        end

        // Asynchronous reset while the second of three flits is on the uplink.
        do_reset();
        cycle(4'b0100, ld(2, 20'h42000), 1'b0);
        cycle(4'b0100, ld(2, 20'h02001), 1'b0);
        cycle(4'b0000, '0, 1'b0);
        check("midrst body out_valid", 32'(out_valid), 1);
        check("midrst body out_data", 32'(out_data), 32'h02001);
        check("midrst busy before", 32'(busy), 1);
        #2 rst = 1'b0;
        model_reset();
        #1;
        check("midrst async out_valid", 32'(out_valid), 0);
        check("midrst async out_data", 32'(out_data), 0);
        check("midrst async in_co", 32'(in_co), 0);
        check("midrst async grant_id", 32'(grant_id), 0);
        check("midrst async busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b1;
        cycle(4'b1000, ld(3, 20'h43100), 1'b0);
        cycle(4'b0000, '0, 1'b0);
        check("midrst regrant out_valid", 32'(out_valid), 1);
        check("midrst regrant out_data", 32'(out_data), 32'h43100);
        check("midrst regrant grant_id", 32'(grant_id), 3);
        check("midrst regrant busy", 32'(busy), 1);

        // Randomized traffic: clean protocol first, then with injected errors.
        do_reset();
        random_phase("rnd_clean", 1500, 1'b0);
        do_reset();
        random_phase("rnd_err", 1500, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
